// File: rtl/can_bit_destuff.sv
// CAN receive bit destuffer: strips stuff bits from the sampled bit stream,
// flags stuff-rule violations and counts removed stuff bits per frame.
module can_bit_destuff #(
    parameter int RUN_LEN = 5,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             rx_bit,
    input  logic             frame_start,
    input  logic             stuff_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             stuff_drop,
    output logic             stuff_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] stuff_count
);

    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0]  RUN_MAX = RC_W'(RUN_LEN);
    localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             run_bit_q, run_bit_d;
    logic [RC_W-1:0]  run_cnt_q, run_cnt_d;
    logic             expect_stuff_q, expect_stuff_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] stuff_count_q, stuff_count_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             stuff_drop_q, stuff_drop_d;
    logic             stuff_err_q, stuff_err_d;

    logic [RC_W-1:0]  cnt_base_s;
    logic             exp_base_s;

    // Next-state logic; frame_start clears frame state before the same-cycle sample is evaluated.
    always_comb begin
        cnt_base_s     = frame_start ? {RC_W{1'b0}} : run_cnt_q;
        exp_base_s     = frame_start ? 1'b0 : expect_stuff_q;
        run_bit_d      = run_bit_q;
        run_cnt_d      = cnt_base_s;
        expect_stuff_d = exp_base_s;
        err_sticky_d   = frame_start ? 1'b0 : err_sticky_q;
        stuff_count_d  = frame_start ? {CNT_W{1'b0}} : stuff_count_q;
        dout_d         = dout_q;
        dout_valid_d   = 1'b0;
        stuff_drop_d   = 1'b0;
        stuff_err_d    = 1'b0;

        if (sample_en) begin
            if (exp_base_s) begin
                // Stuff position is checked even after stuff_en falls (stuff bit after last CRC bit).
                if (rx_bit != run_bit_q) begin
                    stuff_drop_d = 1'b1;
                    run_bit_d    = rx_bit;
                    if (stuff_count_d != CNT_MAX) begin
                        stuff_count_d = stuff_count_d + CNT_ONE;
                    end else begin
                        stuff_count_d = CNT_MAX;
                    end
                end else begin
                    stuff_err_d  = 1'b1;
                    err_sticky_d = 1'b1;
                end
                run_cnt_d      = RC_ONE;
                expect_stuff_d = 1'b0;
            end else if (stuff_en) begin
                dout_d       = rx_bit;
                dout_valid_d = 1'b1;
                if ((rx_bit == run_bit_q) && (cnt_base_s != {RC_W{1'b0}})) begin
                    run_cnt_d = cnt_base_s + RC_ONE;
                end else begin
                    run_bit_d = rx_bit;
                    run_cnt_d = RC_ONE;
                end
                if (run_cnt_d == RUN_MAX) begin
                    expect_stuff_d = 1'b1;
                end else begin
                    expect_stuff_d = 1'b0;
                end
            end else begin
                dout_d       = rx_bit;
                dout_valid_d = 1'b1;
                run_cnt_d    = {RC_W{1'b0}};
            end
        end else begin
            dout_valid_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_bit_q      <= 1'b1;
            run_cnt_q      <= {RC_W{1'b0}};
            expect_stuff_q <= 1'b0;
            err_sticky_q   <= 1'b0;
            stuff_count_q  <= {CNT_W{1'b0}};
            dout_q         <= 1'b0;
            dout_valid_q   <= 1'b0;
            stuff_drop_q   <= 1'b0;
            stuff_err_q    <= 1'b0;
        end else begin
            run_bit_q      <= run_bit_d;
            run_cnt_q      <= run_cnt_d;
            expect_stuff_q <= expect_stuff_d;
            err_sticky_q   <= err_sticky_d;
            stuff_count_q  <= stuff_count_d;
            dout_q         <= dout_d;
            dout_valid_q   <= dout_valid_d;
            stuff_drop_q   <= stuff_drop_d;
            stuff_err_q    <= stuff_err_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign stuff_drop  = stuff_drop_q;
    assign stuff_err   = stuff_err_q;
    assign err_sticky  = err_sticky_q;
    assign stuff_count = stuff_count_q;

endmodule
